// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver recovering bytes from an oversampled rx line
// Start, data and stop bits are sampled mid-bit by counting shared baud ticks.
module uart_rx #(
  parameter int OVS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err
);

  localparam int HALF = OVS / 2;
  localparam logic [3:0] C_HALF_LAST = 4'(HALF - 1);
  localparam logic [3:0] C_BIT_LAST  = 4'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state    <= S_START;
              r_tick_cnt <= '0;
              o_rx_busy  <= 1'b1;
            end
          end
          S_START: begin
            if (r_tick_cnt == C_HALF_LAST) begin
              r_tick_cnt <= '0;
              if (!r_rx_s) begin
                r_state   <= S_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state   <= S_IDLE;
                o_rx_busy <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          S_DATA: begin
            if (r_tick_cnt == C_BIT_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          S_STOP: begin
            if (r_tick_cnt == C_BIT_LAST) begin
              r_tick_cnt <= '0;
              if (r_rx_s) begin
                r_state   <= S_IDLE;
                o_rx_data <= r_shift;
                o_rx_done <= 1'b1;
                o_rx_busy <= 1'b0;
              end else begin
                r_state     <= S_BREAK;
                o_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          S_BREAK: begin
            // A held-low line must go high before another start edge counts.
            if (r_rx_s) begin
              r_state    <= S_IDLE;
              r_tick_cnt <= '0;
              o_rx_busy  <= 1'b0;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            o_rx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
// One baud tick every 4 clks; rx changes settle through the synchronizer before the next tick.
module tb_uart_rx;

  localparam int OVS    = 8;
  localparam int STOP_G = OVS / 2 + 9 * OVS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_rx_busy;
  logic       o_frame_err;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         d0;
  int         e0;
  logic [7:0] got_q[$];
  logic       busy_ok;

  uart_rx #(.OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .o_rx_data  (o_rx_data),
    .o_rx_done  (o_rx_done),
    .o_rx_busy  (o_rx_busy),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt++;
      got_q.push_back(o_rx_data);
    end
    if (o_frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int last_byte();
    if (got_q.size() == 0) return -1;
    return int'(got_q[got_q.size() - 1]);
  endfunction

  task automatic do_tick();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) do_tick();
  endtask

  // Bits flagged in mask last OVS+skew ticks; stops early after max_ticks ticks.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int skew,
                            input logic [9:0] mask, input int max_ticks);
    logic [9:0] bits;
    int g;
    bits    = {stop_v, d, 1'b0};
    g       = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      for (int j = 0; j < (mask[k] ? OVS + skew : OVS); j++) begin
        if (g == max_ticks) return;
        do_tick();
        if (g < STOP_G && o_rx_busy !== 1'b1) busy_ok = 1'b0;
        g++;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", int'(o_rx_data), 'h0);
    chk("rst_done", int'(o_rx_done), 0);
    chk("rst_busy", int'(o_rx_busy), 0);
    chk("rst_err",  int'(o_frame_err), 0);
    rst = 1'b0;
    idle(4);

    // Single frame
    send_frame(8'h55, 1'b1, 0, 10'b0, -1);
    idle(2);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_data", last_byte(), 'h55);
    chk("t1_busy_frame", int'(busy_ok), 1);
    chk("t1_busy_after", int'(o_rx_busy), 0);
    chk("t1_err_cnt", err_cnt, 0);

    // Back-to-back frames with no idle gap
    d0 = done_cnt;
    send_frame(8'hA3, 1'b1, 0, 10'b0, -1);
    send_frame(8'h0F, 1'b1, 0, 10'b0, -1);
    idle(2);
    chk("t2_done_cnt", done_cnt - d0, 2);
    chk("t2_first", (got_q.size() >= 2) ? int'(got_q[got_q.size() - 2]) : -1, 'hA3);
    chk("t2_second", last_byte(), 'h0F);

    // Two-tick glitch: rejected at the mid-start check
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (2) do_tick();
    rx = 1'b1;
    repeat (2) do_tick();
    chk("t3_busy_start", int'(o_rx_busy), 1);
    do_tick();
    chk("t3_busy_drop", int'(o_rx_busy), 0);
    idle(10);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_no_err", err_cnt - e0, 0);
    chk("t3_data_kept", int'(o_rx_data), 'h0F);

    // Bad stop bit, line held low 30 ticks, then recovery
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 0, 10'b0, -1);
    repeat (22) do_tick();
    chk("t4_err_cnt", err_cnt - e0, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_data_kept", int'(o_rx_data), 'h0F);
    chk("t4_busy_break", int'(o_rx_busy), 1);
    idle(1);
    chk("t4_busy_idle", int'(o_rx_busy), 0);
    idle(4);
    send_frame(8'h81, 1'b1, 0, 10'b0, -1);
    idle(2);
    chk("t4_next_done", done_cnt - d0, 1);
    chk("t4_next_data", last_byte(), 'h81);
    chk("t4_err_total", err_cnt - e0, 1);

    // Reset during data bit 4
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'hFF, 1'b1, 0, 10'b0, OVS + 4 * OVS + 4);
    chk("t5_busy_pre", int'(o_rx_busy), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_data", int'(o_rx_data), 'h0);
    chk("t5_rst_busy", int'(o_rx_busy), 0);
    chk("t5_rst_done", int'(o_rx_done), 0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_err", err_cnt - e0, 0);
    send_frame(8'h12, 1'b1, 0, 10'b0, -1);
    idle(2);
    chk("t5_next_done", done_cnt - d0, 1);
    chk("t5_next_data", last_byte(), 'h12);

    // Slow and fast transmitters: 9- or 7-tick bits, spread so drift stays within HALF-1 ticks
    d0 = done_cnt;
    send_frame(8'hC6, 1'b1, 1, 10'b0100100100, -1);
    idle(4);
    chk("t6_slow_done", done_cnt - d0, 1);
    chk("t6_slow_data", last_byte(), 'hC6);
    send_frame(8'hC6, 1'b1, -1, 10'b0100100100, -1);
    idle(4);
    chk("t6_fast_done", done_cnt - d0, 2);
    chk("t6_fast_data", last_byte(), 'hC6);
    chk("t6_err_none", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
